pipeline_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage RISC-V pipeline (Fetch, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Produces per-stage stall and flush/bubble controls from three sources: load-use hazards, EX-stage redirects, and data-memory wait states.
- Adds a debug halt/single-step engine that drains the pipeline before freezing.
- Keeps stall and flush performance counters.
- Sits beside the pipeline registers; all stage registers and the PC take their enables and flushes from this block.

---
 rtl/pipeline_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes, data-memory
// wait freezes and a debug halt/single-step engine, plus stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             pc_stall,
    output logic             fetch_bubble,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [15:0]      flush_events
);

    typedef enum logic [2:0] {
        S_RUN,
        S_MEM_WAIT,
        S_DRAIN,
        S_HALTED,
        S_STEP
    } state_t;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    state_t           eff_state;
    logic [7:0]       drain_cnt_q, drain_cnt_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [15:0]      flush_cnt_q, flush_cnt_d;

    logic freeze, hazard_ok, redir, lu_match, load_use, park;
    logic pc_stall_c, fetch_bubble_c, if_id_stall_c, if_id_flush_c;
    logic id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c, mem_wb_bubble_c, halted_c;

    // On the release cycle of a wait, behave as the state that was interrupted.
    always_comb begin
        eff_state = (state_q == S_MEM_WAIT) ? ret_q : state_q;
        if (state_q == S_MEM_WAIT)
            freeze = !dmem_ready;
        else
            freeze = (state_q != S_HALTED) && mem_req && !dmem_ready;

        hazard_ok = !freeze && (eff_state != S_HALTED);
        redir     = hazard_ok && ex_redirect;
        lu_match  = ex_memread && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));
        load_use  = hazard_ok && !ex_redirect && lu_match;
        park      = !freeze && ((eff_state == S_DRAIN) || (eff_state == S_HALTED));

        pc_stall_c      = freeze || load_use || (park && !redir);
        fetch_bubble_c  = park;
        if_id_stall_c   = freeze || load_use;
        if_id_flush_c   = redir;
        id_ex_stall_c   = freeze;
        id_ex_flush_c   = redir || load_use;
        ex_mem_stall_c  = freeze;
        mem_wb_bubble_c = freeze;
        halted_c        = (state_q == S_HALTED);
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        drain_cnt_d = drain_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q + (pc_stall_c ? CNT_W'(1) : CNT_W'(0));
        flush_cnt_d = (redir && (flush_cnt_q != 16'hFFFF)) ? flush_cnt_q + 16'd1 : flush_cnt_q;

        if (freeze) begin
            state_d = S_MEM_WAIT;
            ret_d   = eff_state;
            if (wait_cnt_q != 8'hFF)
                wait_cnt_d = wait_cnt_q + 8'd1;
            if ((int'(wait_cnt_q) + 1) >= MEM_TIMEOUT)
                err_d = 1'b1;
        end else begin
            wait_cnt_d = 8'd0;
            state_d    = eff_state;
            case (eff_state)
                S_RUN: begin
                    if (halt_req) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = 8'd0;
                    end
                end
                S_DRAIN: begin
                    if (!halt_req)
                        state_d = S_RUN;
                    else if (redir)
                        drain_cnt_d = 8'd0;
                    else if (drain_cnt_q == 8'(DRAIN_CYCLES - 1))
                        state_d = S_HALTED;
                    else
                        drain_cnt_d = drain_cnt_q + 8'd1;
                end
                S_HALTED: begin
                    if (!halt_req)
                        state_d = S_RUN;
                    else if (step_req)
                        state_d = S_STEP;
                end
                S_STEP: begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 8'd0;
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            ret_q       <= S_RUN;
            drain_cnt_q <= 8'd0;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are forced low while reset is held, independent of live inputs.
    assign pc_stall        = rst & pc_stall_c;
    assign fetch_bubble    = rst & fetch_bubble_c;
    assign if_id_stall     = rst & if_id_stall_c;
    assign if_id_flush     = rst & if_id_flush_c;
    assign id_ex_stall     = rst & id_ex_stall_c;
    assign id_ex_flush     = rst & id_ex_flush_c;
    assign ex_mem_stall    = rst & ex_mem_stall_c;
    assign mem_wb_bubble   = rst & mem_wb_bubble_c;
    assign halted          = rst & halted_c;
    assign mem_timeout_err = err_q;
    assign stall_cycles    = stall_cnt_q;
    assign flush_events    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for single-cycle hazards,
// hand-written sequences for memory freeze, timeout, halt/step and reset.
module tb_pipeline_hazard_ctrl;

    logic        clk, rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_memread, ex_redirect;
    logic        mem_req, dmem_ready, halt_req, step_req;
    logic        pc_stall, fetch_bubble, if_id_stall, if_id_flush;
    logic        id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, halted;
    logic        mem_timeout_err;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;
    logic [8:0]  ctrl;

    int checks = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .step_req(step_req),
        .pc_stall(pc_stall), .fetch_bubble(fetch_bubble),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
        .halted(halted), .mem_timeout_err(mem_timeout_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    assign ctrl = {pc_stall, fetch_bubble, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_stall, mem_wb_bubble, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control patterns, bit order as in ctrl above.
    localparam logic [8:0] Z   = 9'b000000000;
    localparam logic [8:0] LU  = 9'b101001000;
    localparam logic [8:0] RD  = 9'b000101000;
    localparam logic [8:0] FZ  = 9'b101010110;
    localparam logic [8:0] DR  = 9'b110000000;
    localparam logic [8:0] HL  = 9'b110000001;
    localparam logic [8:0] DRR = 9'b010101000;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2, mr;
        logic [4:0] rd;
        logic       redir, mreq, rdy, hlt, stp;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic u1,
                                logic u2, logic mr, logic [4:0] rd, logic redir,
                                logic mreq, logic rdy, logic hlt, logic stp, logic [8:0] e);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr;
        v.rd = rd; v.redir = redir; v.mreq = mreq; v.rdy = rdy; v.hlt = hlt;
        v.stp = stp; v.exp = e;
        return v;
    endfunction

    function automatic vec_t hv(string n, logic redir, logic mreq, logic rdy,
                                logic hlt, logic stp, logic [8:0] e);
        return mk(n, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, redir, mreq, rdy, hlt, stp, e);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
        ex_memread = v.mr; ex_rd = v.rd; ex_redirect = v.redir;
        mem_req = v.mreq; dmem_ready = v.rdy; halt_req = v.hlt; step_req = v.stp;
    endtask

    // Apply one cycle of inputs, check controls mid-cycle, advance past the edge.
    task automatic run(vec_t v);
        drive(v);
        @(negedge clk);
        chk(v.name, {23'd0, ctrl}, {23'd0, v.exp});
        $display("vec %-12s ctrl=%09b exp=%09b stall=%0d flush=%0d err=%0b",
                 v.name, ctrl, v.exp, stall_cycles, flush_events, mem_timeout_err);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(hv("idle", 0, 0, 1, 0, 0, Z));
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(hv("idle", 0, 0, 1, 0, 0, Z));
        tbl.push_back(mk("lu_rs1", 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 1, 0, 0, LU));
        tbl.push_back(hv("after_lu", 0, 0, 1, 0, 0, Z));
        tbl.push_back(mk("lu_rd0", 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 1, 0, 0, Z));
        tbl.push_back(mk("lu_rs2", 5'd1, 5'd7, 0, 1, 1, 5'd7, 0, 0, 1, 0, 0, LU));
        tbl.push_back(mk("rs2_unused", 5'd1, 5'd7, 1, 0, 1, 5'd7, 0, 0, 1, 0, 0, Z));
        tbl.push_back(mk("no_load", 5'd5, 5'd5, 1, 1, 0, 5'd5, 0, 0, 1, 0, 0, Z));
        tbl.push_back(mk("redir_lu", 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 1, 0, 0, RD));
        tbl.push_back(hv("redir", 1, 0, 1, 0, 0, RD));
        tbl.push_back(hv("mem_ready", 0, 1, 1, 0, 0, Z));

        drive(hv("idle", 0, 0, 1, 0, 0, Z));
        rst = 1'b0;
        #2;
        chk("reset_ctrl", {23'd0, ctrl}, 32'd0);
        chk("reset_stall", stall_cycles, 32'd0);
        chk("reset_flush", {16'd0, flush_events}, 32'd0);
        chk("reset_err", {31'd0, mem_timeout_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (tbl[i]) run(tbl[i]);
        chk("tbl_stall", stall_cycles, 32'd2);
        chk("tbl_flush", {16'd0, flush_events}, 32'd2);

        // Freeze with a redirect held throughout; redirect accepted only on release.
        do_reset();
        for (int i = 0; i < 3; i++) run(hv("frz_redir", 1, 1, 0, 0, 0, FZ));
        chk("frz_flush", {16'd0, flush_events}, 32'd0);
        run(hv("frz_release", 1, 1, 1, 0, 0, RD));
        chk("rel_flush", {16'd0, flush_events}, 32'd1);
        chk("rel_stall", stall_cycles, 32'd3);
        chk("rel_err", {31'd0, mem_timeout_err}, 32'd0);

        // Timeout: error appears after the fourth frozen edge and is sticky.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run(hv("tmo_wait", 0, 1, 0, 0, 0, FZ));
            chk("tmo_err", {31'd0, mem_timeout_err}, (i >= 3) ? 32'd1 : 32'd0);
        end
        run(hv("tmo_release", 0, 1, 1, 0, 0, Z));
        run(hv("tmo_idle", 0, 0, 1, 0, 0, Z));
        chk("tmo_sticky", {31'd0, mem_timeout_err}, 32'd1);

        // Halt, drain, single step, resume.
        do_reset();
        run(hv("halt_run", 0, 0, 1, 1, 0, Z));
        for (int i = 0; i < 4; i++) run(hv("drain", 0, 0, 1, 1, 0, DR));
        run(hv("halted", 0, 0, 1, 1, 0, HL));
        run(hv("halted", 0, 0, 1, 1, 0, HL));
        run(hv("step_req", 0, 0, 1, 1, 1, HL));
        run(hv("step", 0, 0, 1, 1, 0, Z));
        for (int i = 0; i < 4; i++) run(hv("step_drain", 0, 0, 1, 1, 0, DR));
        run(hv("halted2", 0, 0, 1, 1, 0, HL));
        run(hv("unhalt", 0, 0, 1, 0, 0, HL));
        run(hv("resumed", 0, 0, 1, 0, 0, Z));
        chk("halt_stall", stall_cycles, 32'd13);

        // Asynchronous reset while frozen in a memory wait.
        do_reset();
        run(hv("pre_redir", 1, 0, 1, 0, 0, RD));
        run(hv("wait_a", 0, 1, 0, 0, 0, FZ));
        run(hv("wait_b", 0, 1, 0, 0, 0, FZ));
        drive(hv("wait_c", 0, 1, 0, 0, 0, FZ));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ctrl", {23'd0, ctrl}, 32'd0);
        chk("arst_stall", stall_cycles, 32'd0);
        chk("arst_flush", {16'd0, flush_events}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(hv("post_rst", 0, 0, 1, 0, 0, Z));
        run(mk("post_lu", 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 1, 0, 0, LU));
        run(hv("post_idle", 0, 0, 1, 0, 0, Z));

        // Redirect restarts drain; halt_req dropping in DRAIN returns to RUN.
        run(hv("h2_run", 0, 0, 1, 1, 0, Z));
        run(hv("h2_drain", 0, 0, 1, 1, 0, DR));
        run(hv("h2_drain", 0, 0, 1, 1, 0, DR));
        run(hv("h2_redir", 1, 0, 1, 1, 0, DRR));
        for (int i = 0; i < 4; i++) run(hv("h2_redrain", 0, 0, 1, 1, 0, DR));
        run(hv("h2_halted", 0, 0, 1, 1, 0, HL));
        run(hv("h2_unhalt", 0, 0, 1, 0, 0, HL));
        run(hv("h3_run", 0, 0, 1, 1, 0, Z));
        run(hv("h3_drain", 0, 0, 1, 1, 0, DR));
        run(hv("h3_drop", 0, 0, 1, 0, 0, DR));
        run(hv("h3_resumed", 0, 0, 1, 0, 0, Z));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
